fifo_rd_stage: RTL and testbench

FIFO_RD_STAGE -- requirements
Module: fifo_rd_stage

---
 rtl/fifo_rd_stage.sv | 126 ++++++++++++
 tb/tb_fifo_rd_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stage.sv
// fifo_rd_stage
//   Read-side stage behind an async FIFO. Pops entries from the FIFO into a
//   2-entry in-order buffer (head, tail) and presents the head to a
//   valid/ready consumer. rinc depends only on registered state and FIFO/flush
//   inputs, so there is no combinational path from out_ready back to the FIFO.
//
// Ports
//   rclk       read-side clock, rising edge
//   rrst_n     asynchronous active-low reset
//   rempty     FIFO empty flag (low: rdata valid)
//   rdata      FIFO head entry
//   rinc       FIFO pop strobe
//   out_data   buffered head entry
//   out_valid  out_data holds a valid entry
//   out_ready  consumer accepts out_data on this edge
//   flush      synchronous discard of all buffered entries
//   level      buffered entry count, 0..2
//   xfer_cnt   count of completed output transfers (wraps)
module fifo_rd_stage #(
   parameter int DSIZE = 5,
   parameter int CW    = 16
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   output logic [DSIZE-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             flush,
   output logic [1:0]       level,
   output logic [CW-1:0]    xfer_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [DSIZE-1:0] head_q, head_d;
   logic [DSIZE-1:0] tail_q, tail_d;
   logic [CW-1:0]    xfer_cnt_q, xfer_cnt_d;

   logic push;
   logic pop;

   // State and datapath registers
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q    <= EMPTY;
         head_q     <= '0;
         tail_q     <= '0;
         xfer_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   // Next-state and buffer update
   always_comb begin
      state_d    = state_q;
      head_d     = head_q;
      tail_d     = tail_q;
      xfer_cnt_d = xfer_cnt_q;

      if (pop) begin
         xfer_cnt_d = xfer_cnt_q + CW'(1);
      end

      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (push) begin
                  head_d  = rdata;
                  state_d = ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  // Old head leaves, incoming entry takes its place.
                  head_d = rdata;
               end else if (push) begin
                  tail_d  = rdata;
                  state_d = FULL;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head_d  = tail_q;
                  state_d = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Outputs
   always_comb begin
      // rrst_n gating keeps rinc low while reset is held, so nothing is
      // consumed from the FIFO on an edge that the buffer would discard.
      push      = rrst_n && !rempty && !flush && (state_q != FULL);
      out_valid = (state_q != EMPTY);
      pop       = out_valid && out_ready && !flush;
      rinc      = push;
      out_data  = head_q;
      xfer_cnt  = xfer_cnt_q;
      case (state_q)
         EMPTY:   level = 2'd0;
         ONE:     level = 2'd1;
         FULL:    level = 2'd2;
         default: level = 2'd0;
      endcase
   end

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Self-checking bench for fifo_rd_stage: table of directed vectors plus
// hand-written multi-cycle sequences (streaming, back-pressure, flush,
// counter wrap, asynchronous reset).
module tb_fifo_rd_stage;

   localparam int DSIZE = 5;
   localparam int CW    = 4;

   logic             rclk;
   logic             rrst_n;
   logic             rempty;
   logic [DSIZE-1:0] rdata;
   logic             rinc;
   logic [DSIZE-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             flush;
   logic [1:0]       level;
   logic [CW-1:0]    xfer_cnt;

   fifo_rd_stage #(.DSIZE(DSIZE), .CW(CW)) dut (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flush     (flush),
      .level     (level),
      .xfer_cnt  (xfer_cnt)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance past the next rising edge; outputs then show post-edge state.
   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic do_reset();
      rrst_n = 1'b0;
      #1;
      tick();
      rrst_n = 1'b1;
   endtask

   typedef struct {
      logic             rempty;
      logic [DSIZE-1:0] rdata;
      logic             ready;
      logic             flush;
      logic             e_rinc;
      logic             e_valid;
      logic [1:0]       e_level;
      logic             chk_data;
      logic [DSIZE-1:0] e_data;
      logic [CW-1:0]    e_cnt;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int idx;
      int exp_idx;
      int n_xfer;
      int first_k;
      logic got_rinc;
      logic [CW-1:0] cnt_snap;

      // rempty, rdata, ready, flush | rinc, valid, level, chk, data, cnt
      vecs[0]  = '{1'b0, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0,  4'd0};
      vecs[1]  = '{1'b0, 5'd3,  1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 5'd3,  4'd0};
      vecs[2]  = '{1'b0, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 5'd3,  4'd0};
      vecs[3]  = '{1'b0, 5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 5'd3,  4'd0};
      vecs[4]  = '{1'b0, 5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 5'd3,  4'd1};
      vecs[5]  = '{1'b0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 5'd9,  4'd2};
      vecs[6]  = '{1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 5'd9,  4'd2};
      vecs[7]  = '{1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 5'd12, 4'd3};
      vecs[8]  = '{1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  4'd4};
      vecs[9]  = '{1'b0, 5'd21, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0,  4'd4};
      vecs[10] = '{1'b0, 5'd21, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 5'd0,  4'd4};
      vecs[11] = '{1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 5'd21, 4'd4};

      rrst_n    = 1'b0;
      rempty    = 1'b0;
      rdata     = 5'd17;
      out_ready = 1'b1;
      flush     = 1'b0;

      // Reset state (rempty low must not produce rinc while in reset)
      #12;
      check("rst_rinc",  int'(rinc), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_level", int'(level), 0);
      check("rst_cnt",   int'(xfer_cnt), 0);
      check("rst_data",  int'(out_data), 0);
      tick();
      check("rst_edge_valid", int'(out_valid), 0);
      rrst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 12; i++) begin
         rempty    = vecs[i].rempty;
         rdata     = vecs[i].rdata;
         out_ready = vecs[i].ready;
         flush     = vecs[i].flush;
         #1;
         check($sformatf("vec%0d_rinc", i),  int'(rinc), int'(vecs[i].e_rinc));
         check($sformatf("vec%0d_valid", i), int'(out_valid), int'(vecs[i].e_valid));
         check($sformatf("vec%0d_level", i), int'(level), int'(vecs[i].e_level));
         check($sformatf("vec%0d_cnt", i),   int'(xfer_cnt), int'(vecs[i].e_cnt));
         if (vecs[i].chk_data)
            check($sformatf("vec%0d_data", i), int'(out_data), int'(vecs[i].e_data));
         tick();
      end

      // Streaming 0..9 with out_ready held high
      do_reset();
      idx = 0; exp_idx = 0; first_k = -1;
      out_ready = 1'b1; flush = 1'b0;
      for (int k = 0; k < 13; k++) begin
         rempty = (idx >= 10);
         rdata  = DSIZE'(idx);
         #1;
         got_rinc = rinc;
         if (out_valid) begin
            if (first_k < 0) first_k = k;
            check($sformatf("stream_data%0d", exp_idx), int'(out_data), exp_idx);
            exp_idx++;
         end
         tick();
         if (got_rinc) idx++;
      end
      check("stream_first_cycle", first_k, 1);
      check("stream_count", exp_idx, 10);
      check("stream_xfer_cnt", int'(xfer_cnt), 10);
      check("stream_end_valid", int'(out_valid), 0);
      check("stream_end_rinc", int'(rinc), 0);

      // Back-pressure from FULL(4,5), next FIFO entry 6
      do_reset();
      out_ready = 1'b0; rempty = 1'b0; rdata = 5'd4;
      tick();
      rdata = 5'd5;
      tick();
      check("bp_full_level", int'(level), 2);
      out_ready = 1'b1; rdata = 5'd6; #1;
      check("bp_out0", int'(out_data), 4);
      check("bp_rinc_full", int'(rinc), 0);
      tick();
      out_ready = 1'b0; #1;
      check("bp_out1", int'(out_data), 5);
      check("bp_rinc_one", int'(rinc), 1);
      tick();
      out_ready = 1'b1; rempty = 1'b1; #1;
      check("bp_hold_data", int'(out_data), 5);
      check("bp_hold_valid", int'(out_valid), 1);
      tick();
      #1;
      check("bp_out2", int'(out_data), 6);
      check("bp_out2_valid", int'(out_valid), 1);
      tick();
      check("bp_drained", int'(out_valid), 0);
      check("bp_cnt", int'(xfer_cnt), 3);

      // Flush from FULL with rempty low and out_ready high
      out_ready = 1'b0; rempty = 1'b0; rdata = 5'd1;
      tick();
      rdata = 5'd2;
      tick();
      check("fl_full_level", int'(level), 2);
      cnt_snap = xfer_cnt;
      flush = 1'b1; out_ready = 1'b1; #1;
      check("fl_rinc", int'(rinc), 0);
      tick();
      flush = 1'b0; rempty = 1'b1; #1;
      check("fl_level", int'(level), 0);
      check("fl_valid", int'(out_valid), 0);
      check("fl_cnt", int'(xfer_cnt), int'(cnt_snap));

      // Counter wrap with CW=4 over 17 transfers
      do_reset();
      n_xfer = 0; out_ready = 1'b1; rempty = 1'b0; flush = 1'b0;
      for (int k = 0; k < 40 && n_xfer < 17; k++) begin
         rdata = DSIZE'(k);
         #1;
         if (out_valid) begin
            tick();
            n_xfer++;
            if (n_xfer >= 15)
               check($sformatf("wrap_cnt_after_%0d", n_xfer), int'(xfer_cnt), n_xfer % 16);
         end else begin
            tick();
         end
      end
      check("wrap_xfers_done", n_xfer, 17);

      // Asynchronous reset while in ONE with out_ready low
      do_reset();
      out_ready = 1'b0; rempty = 1'b0; rdata = 5'd11;
      tick();
      rempty = 1'b1; #1;
      check("ar_pre_level", int'(level), 1);
      #2;
      rrst_n = 1'b0; rempty = 1'b0; #1;
      check("ar_valid", int'(out_valid), 0);
      check("ar_level", int'(level), 0);
      check("ar_rinc", int'(rinc), 0);
      tick();
      rrst_n = 1'b1; rempty = 1'b1; out_ready = 1'b1;
      tick();
      check("ar_no_reissue", int'(out_valid), 0);
      check("ar_cnt", int'(xfer_cnt), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
